// File: rtl/conv_output_packer_pkg.sv
// Shared widths and FSM state type for the convolution output packer.
package conv_output_packer_pkg;

    localparam int CONV_DATA_W = 16;
    localparam int CONV_ADDR_W = 12;
    localparam int CONV_COL_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        HDR   = 2'd3
    } packer_state_t;

endpackage

// File: rtl/conv_output_packer_if.sv
// Pixel stream in and SRAM write port out; master drives pixels, slave is the packer.
interface conv_output_packer_if
    import conv_output_packer_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int ADDR_W = CONV_ADDR_W,
    parameter int COL_W  = CONV_COL_W
);
    logic              pix_valid;
    logic              pix_bit;
    logic [COL_W-1:0]  pix_col;
    logic [ADDR_W-1:0] pix_waddr;
    logic              pix_row_last;

    logic              dut_sram_write_enable;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;

    modport master (
        output pix_valid, pix_bit, pix_col, pix_waddr, pix_row_last,
        input  dut_sram_write_enable, dut_sram_write_address, dut_sram_write_data
    );

    modport slave (
        input  pix_valid, pix_bit, pix_col, pix_waddr, pix_row_last,
        output dut_sram_write_enable, dut_sram_write_address, dut_sram_write_data
    );
endinterface

// File: rtl/conv_output_packer_row_bit_accum.sv
// Row accumulator: holds the partial row word, its address and a nonempty flag.
module row_bit_accum #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int COL_W  = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              clr,
    input  logic              set_en,
    input  logic              fresh,
    input  logic              row_end,
    input  logic [COL_W-1:0]  set_col,
    input  logic              set_bit,
    input  logic [ADDR_W-1:0] set_addr,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] merged,
    output logic              nonempty,
    output logic [ADDR_W-1:0] row_addr
);
    // merged is the word including this cycle's pixel; fresh discards the held row first
    always_comb begin
        merged          = fresh ? '0 : acc;
        merged[set_col] = set_bit;
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            acc      <= '0;
            nonempty <= 1'b0;
            row_addr <= '0;
        end else if (clr) begin
            acc      <= '0;
            nonempty <= 1'b0;
        end else if (set_en) begin
            row_addr <= set_addr;
            if (row_end) begin
                acc      <= '0;
                nonempty <= 1'b0;
            end else begin
                acc      <= merged;
                nonempty <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/conv_output_packer.sv
// Packs per-pixel result bits into row words and owns the SRAM write port.
// Optional header word after each frame: define CONV_OUT_HDR_EN.
module conv_output_packer
    import conv_output_packer_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int ADDR_W = CONV_ADDR_W,
    parameter int COL_W  = CONV_COL_W
`ifdef CONV_OUT_HDR_EN
    ,
    parameter logic [ADDR_W-1:0] HDR_ADDR = '0
`endif
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              frame_start,
    input  logic              frame_done,
    conv_output_packer_if.slave bus,
    output logic              packer_busy,
    output logic [ADDR_W-1:0] rows_written
);
`ifdef CONV_OUT_HDR_EN
    localparam packer_state_t POST_FLUSH = HDR;
`else
    localparam packer_state_t POST_FLUSH = IDLE;
`endif

    packer_state_t     state, state_n;
    logic              wr_en, wr_en_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic [DATA_W-1:0] wr_data, wr_data_n;
    logic              row_inc, acc_clr;
    logic              accept, addr_chg, row_end;
    logic [DATA_W-1:0] acc, merged;
    logic              nonempty;
    logic [ADDR_W-1:0] row_addr;

    assign accept   = (state == ACCUM) && bus.pix_valid && !frame_start;
    assign addr_chg = accept && nonempty && (bus.pix_waddr != row_addr);
    // a row_last pixel that also changes address starts a new held row instead of
    // completing one, so only a single write is issued this cycle
    assign row_end  = bus.pix_row_last && !addr_chg;

    row_bit_accum #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COL_W(COL_W)) u_accum (
        .clk      (clk),
        .reset_b  (reset_b),
        .clr      (acc_clr),
        .set_en   (accept),
        .fresh    (addr_chg),
        .row_end  (row_end),
        .set_col  (bus.pix_col),
        .set_bit  (bus.pix_bit),
        .set_addr (bus.pix_waddr),
        .acc      (acc),
        .merged   (merged),
        .nonempty (nonempty),
        .row_addr (row_addr)
    );

    always_ff @(posedge clk) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        row_inc   = 1'b0;
        acc_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_n = ACCUM;
            end
            ACCUM: begin
                if (addr_chg) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = row_addr;
                    wr_data_n = acc;
                    row_inc   = 1'b1;
                end else if (accept && bus.pix_row_last) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = bus.pix_waddr;
                    wr_data_n = merged;
                    row_inc   = 1'b1;
                end
                if (frame_done)
                    state_n = (accept ? !row_end : nonempty) ? FLUSH : POST_FLUSH;
            end
            FLUSH: begin
                wr_en_n   = 1'b1;
                wr_addr_n = row_addr;
                wr_data_n = acc;
                row_inc   = 1'b1;
                acc_clr   = 1'b1;
                state_n   = POST_FLUSH;
            end
`ifdef CONV_OUT_HDR_EN
            HDR: begin
                wr_en_n   = 1'b1;
                wr_addr_n = HDR_ADDR;
                wr_data_n = DATA_W'(rows_written);
                state_n   = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
        // a new frame abandons anything held from the previous one
        if (frame_start) begin
            state_n = ACCUM;
            wr_en_n = 1'b0;
            row_inc = 1'b0;
            acc_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            rows_written <= '0;
        end else begin
            wr_en <= wr_en_n;
            if (wr_en_n) begin
                wr_addr <= wr_addr_n;
                wr_data <= wr_data_n;
            end
            if (frame_start)  rows_written <= '0;
            else if (row_inc) rows_written <= rows_written + 1'b1;
        end
    end

    assign bus.dut_sram_write_enable  = wr_en;
    assign bus.dut_sram_write_address = wr_addr;
    assign bus.dut_sram_write_data    = wr_data;
    assign packer_busy                = (state != IDLE) || wr_en;
endmodule

// File: tb/tb_conv_output_packer.sv
// Bench for conv_output_packer: table rows, directed corner sequences, random frames vs row-word model.
module tb_conv_output_packer;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_done = 1'b0;
    logic        packer_busy;
    logic [11:0] rows_written;

    conv_output_packer_if bus ();

    conv_output_packer dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .bus          (bus.slave),
        .packer_busy  (packer_busy),
        .rows_written (rows_written)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] obs_addr[$];
    logic [15:0] obs_data[$];
    int          obs_cyc[$];
    logic [11:0] exp_addr[$];
    logic [15:0] exp_data[$];

    always @(negedge clk) begin
        if (bus.dut_sram_write_enable) begin
            obs_addr.push_back(bus.dut_sram_write_address);
            obs_data.push_back(bus.dut_sram_write_data);
            obs_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [11:0] addr;
        logic [15:0] mask;
        int          ncols;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic fs, input logic pv, input logic b, input logic [3:0] col,
                        input logic [11:0] a, input logic last, input logic fd);
        @(negedge clk);
        frame_start      = fs;
        bus.pix_valid    = pv;
        bus.pix_bit      = b;
        bus.pix_col      = col;
        bus.pix_waddr    = a;
        bus.pix_row_last = last;
        frame_done       = fd;
    endtask

    task automatic pix(input logic [11:0] a, input logic [3:0] col, input logic b, input logic last);
        step(1'b0, 1'b1, b, col, a, last, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b0);
    endtask

    task automatic expect_wr(input logic [11:0] a, input logic [15:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic start_frame();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        exp_addr.delete(); exp_data.delete();
        step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b0);
    endtask

    // wait for busy to drop, then compare writes and the row counter
    task automatic drain(input int nrows);
        logic last_wr;
        int   k;
        last_wr = bus.dut_sram_write_enable;
`ifdef CONV_OUT_HDR_EN
        expect_wr(12'h000, 16'(nrows));
`endif
        for (k = 0; k < 40; k++) begin
            idle();
            if (!packer_busy) break;
            last_wr = bus.dut_sram_write_enable;
        end
        chk("busy_timeout", {31'd0, packer_busy}, 32'd0);
        chk("busy_fall", {31'd0, (k == 0) || last_wr}, 32'd1);
        repeat (2) idle();
        chk("nwrites", obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk("wr_addr", {20'd0, obs_addr[i]}, {20'd0, exp_addr[i]});
            chk("wr_data", {16'd0, obs_data[i]}, {16'd0, exp_data[i]});
        end
        chk("rows_written", {20'd0, rows_written}, 32'(nrows));
    endtask

    task automatic end_frame(input int nrows);
        step(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1);
        drain(nrows);
    endtask

    initial begin
        int          pcyc;
        logic [15:0] word;
        logic [11:0] base, a;
        int          nrows, npix;
        logic [3:0]  col;
        logic        b, last;

        bus.pix_valid = 0; bus.pix_bit = 0; bus.pix_col = 0; bus.pix_waddr = 0; bus.pix_row_last = 0;
        tbl[0] = '{12'h010, 16'h2005, 14, 16'h2005};
        tbl[1] = '{12'h0FF, 16'hFFFF, 16, 16'hFFFF};
        tbl[2] = '{12'hFFF, 16'h8001, 16, 16'h8001};
        tbl[3] = '{12'h001, 16'h0000, 16, 16'h0000};
        tbl[4] = '{12'h100, 16'hFFFF, 4,  16'h000F};
        tbl[5] = '{12'h0AA, 16'hA5A5, 1,  16'h0001};

        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, bus.dut_sram_write_enable}, 32'd0);
        chk("rst_addr", {20'd0, bus.dut_sram_write_address}, 32'd0);
        chk("rst_data", {16'd0, bus.dut_sram_write_data}, 32'd0);
        chk("rst_busy", {31'd0, packer_busy}, 32'd0);
        chk("rst_rows", {20'd0, rows_written}, 32'd0);
        reset_b = 1'b1;
        idle();

        // single-row table, write one cycle after the row_last pixel
        for (int t = 0; t < 6; t++) begin
            start_frame();
            for (int c = 0; c < tbl[t].ncols; c++)
                pix(tbl[t].addr, 4'(c), tbl[t].mask[c], c == tbl[t].ncols - 1);
            pcyc = cyc;
            expect_wr(tbl[t].addr, tbl[t].exp);
            end_frame(1);
            if (obs_cyc.size() > 0) chk("latency", obs_cyc[0], pcyc + 1);
        end

        // back-to-back rows
        start_frame();
        pix(12'h011, 4'd0, 1'b1, 1'b0);
        pix(12'h011, 4'd1, 1'b0, 1'b0);
        pix(12'h011, 4'd2, 1'b1, 1'b1);
        pix(12'h012, 4'd0, 1'b1, 1'b1);
        expect_wr(12'h011, 16'h0005);
        expect_wr(12'h012, 16'h0001);
        end_frame(2);

        // address change mid-row flushes the held word the next cycle
        start_frame();
        for (int c = 0; c < 4; c++) pix(12'h020, 4'(c), 1'b1, 1'b0);
        pix(12'h021, 4'd0, 1'b1, 1'b0);
        pcyc = cyc;
        pix(12'h021, 4'd1, 1'b0, 1'b1);
        expect_wr(12'h020, 16'h000F);
        expect_wr(12'h021, 16'h0001);
        end_frame(2);
        if (obs_cyc.size() > 0) chk("chg_latency", obs_cyc[0], pcyc + 1);

        // frame_done with pending bits
        start_frame();
        for (int c = 0; c < 3; c++) pix(12'h030, 4'(c), 1'b1, 1'b0);
        expect_wr(12'h030, 16'h0007);
        end_frame(1);

        // frame_done together with a pixel, plus column overwrite (last wins)
        start_frame();
        pix(12'h040, 4'd0, 1'b1, 1'b0);
        pix(12'h040, 4'd5, 1'b1, 1'b0);
        pix(12'h040, 4'd5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'd3, 12'h040, 1'b0, 1'b1);
        expect_wr(12'h040, 16'h0009);
        drain(1);

        // frame_start mid-row drops the held bits and clears the counter
        start_frame();
        pix(12'h070, 4'd0, 1'b1, 1'b1);
        pix(12'h070, 4'd1, 1'b1, 1'b0);
        repeat (2) idle();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        step(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b0);
        pix(12'h071, 4'd2, 1'b1, 1'b1);
        expect_wr(12'h071, 16'h0004);
        end_frame(1);

        // pixels and frame_done in IDLE are ignored
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        pix(12'h060, 4'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 1'b0, 1'b1);
        repeat (3) idle();
        chk("idle_nowrite", obs_addr.size(), 0);
        chk("idle_busy", {31'd0, packer_busy}, 32'd0);
        chk("idle_rows_hold", {20'd0, rows_written}, 32'd1);

        // reset mid-row
        start_frame();
        for (int c = 0; c < 3; c++) pix(12'h050, 4'(c), 1'b1, 1'b0);
        @(negedge clk);
        reset_b = 1'b0;
        bus.pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_nowrite", obs_addr.size(), 0);
        chk("rstmid_we", {31'd0, bus.dut_sram_write_enable}, 32'd0);
        chk("rstmid_busy", {31'd0, packer_busy}, 32'd0);
        chk("rstmid_rows", {20'd0, rows_written}, 32'd0);
        chk("rstmid_data", {16'd0, bus.dut_sram_write_data}, 32'd0);
        reset_b = 1'b1;
        idle();
        start_frame();
        pix(12'h051, 4'd5, 1'b1, 1'b1);
        expect_wr(12'h051, 16'h0020);
        end_frame(1);

        // five rows (header carries the count when enabled)
        start_frame();
        for (int r = 0; r < 5; r++) begin
            pix(12'h080 + 12'(r), 4'(r), 1'b1, 1'b0);
            pix(12'h080 + 12'(r), 4'd15, 1'b1, 1'b1);
            expect_wr(12'h080 + 12'(r), 16'h8000 | (16'h1 << r));
        end
        end_frame(5);

        // random frames: each generated row must appear as one write of its folded word
        for (int f = 0; f < 25; f++) begin
            start_frame();
            nrows = $urandom_range(1, 5);
            base  = 12'($urandom);
            for (int r = 0; r < nrows; r++) begin
                a    = base + 12'(r);
                npix = $urandom_range(2, 8);
                word = '0;
                for (int p = 0; p < npix; p++) begin
                    col  = 4'($urandom_range(0, 15));
                    b    = 1'($urandom);
                    last = (p == npix - 1) && ($urandom_range(0, 3) != 0);
                    word[col] = b;
                    pix(a, col, b, last);
                    if ($urandom_range(0, 4) == 0) idle();
                end
                expect_wr(a, word);
            end
            end_frame(nrows);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
